counter_call_sched: RTL
=======================

Name: counter_call_sched

Overview:
- Scheduler that sequences a Kami/Bluespec-generated counter's action-value method (EN/RDY/RV handshake) from a single fast system clock.
- Replaces a ripple-divided clock: the counter runs on the same clock, and calls are issued at a programmable prescaled rate (run mode) or one per step pulse.
- Captures each returned value for LEDs or other consumers.
- Counts triggers lost while a call is still pending.

Parameters:
- PRESCALE_W, 21, width of the free-running prescaler counter.
- RV_W, 4, width of the method return value.
- MISS_W, 8, width of the saturating missed-trigger counter.
- TIMEOUT_CYC, 1024, cycles to wait for RDY before abandoning a call (used only with the optional feature).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- run_i  input  1  1 = periodic calls on prescaler tick; 0 = step mode.
- step_i  input  1  single-cycle pulse; requests one call in step mode.
- div_sel_i  input  5  prescaler bit index whose rising edge generates a tick.
- meth_rdy_i  input  1  method ready from the counter.
- meth_rv_i  input  RV_W  method return value; valid in the cycle meth_en_o=1.
- meth_en_o  output  1  method enable; never 1 unless meth_rdy_i=1 in the same cycle.
- value_o  output  RV_W  last captured return value.
- value_vld_o  output  1  one-cycle pulse when value_o updates.
- busy_o  output  1  call pending (state PEND).
- missed_o  output  MISS_W  saturating count of dropped triggers.
- timeout_o  output  1  sticky abandoned-call flag; 0 when the optional feature is off.

Behaviour:
- Reset (async, RST_N=0): prescaler=0, prev_bit=0, state=IDLE, value_o=0, value_vld_o=0, missed_o=0, timeout_o=0. meth_en_o=0 and busy_o=0 as functions of state=IDLE.
- Prescaler: increments every cycle and wraps 2^PRESCALE_W-1 -> 0.
  - Effective index = min(div_sel_i, PRESCALE_W-1).
  - prev_bit registers the selected bit every cycle.
  - tick = sel_bit & ~prev_bit, i.e. a one-cycle pulse every 2^(idx+1) cycles.
  - Changing div_sel_i may produce at most one extra tick in that cycle; this is acceptable.
- trigger = (run_i & tick) | (~run_i & step_i). step_i is ignored while run_i=1.
- FSM, two states:
  - IDLE: busy_o=0, meth_en_o=0. If trigger, go to PEND.
  - PEND: busy_o=1. meth_en_o = meth_rdy_i (combinational). When meth_en_o=1, capture meth_rv_i into value_o, set value_vld_o=1 next cycle, and return to IDLE.
- Exactly one method call per accepted trigger. EN is one cycle per call.
- Latency: trigger in cycle N gives PEND in N+1. If RDY is high, EN is in N+1, and value_o/value_vld_o change in N+2.
- Trigger while in PEND: dropped. missed_o += 1, saturating at 2^MISS_W-1.
- Trigger in the same cycle as EN is also dropped (state is still PEND).
- run_i falling while in PEND: the pending call still completes.
- RDY low in PEND: wait indefinitely, unless the optional feature is enabled.
- value_vld_o is a pulse only, de-asserted in every other cycle.

Optional Feature:
- Macro SCHED_RDY_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to PEND and increments each PEND cycle with meth_rdy_i=0.
  - When it reaches TIMEOUT_CYC: return to IDLE with no EN, no value update, and set timeout_o=1.
  - timeout_o is sticky until reset.
- Undefined: no wait counter, timeout_o tied 0, and PEND waits forever.

Test Plan:
- PRESCALE_W=4, div_sel_i=1, run_i=1, RDY held 1, RV ramps 0,1,2... -> EN pulse every 4 cycles; value_o steps 0,1,2; value_vld_o 1 cycle after each EN; missed_o=0.
- run_i=0, step_i pulse with RDY=1 -> exactly one EN in the next cycle; value_o updates 2 cycles after the step; further ticks cause no EN.
- run_i=0, RDY=0, step pulse, 3 more step pulses, then RDY=1 after 10 cycles -> one EN only; missed_o=3; busy_o high for 10 cycles.
- MISS_W=2, RDY=0, 6 triggers while pending -> missed_o saturates at 3.
- Assert RST_N=0 asynchronously mid-PEND -> immediately busy_o=0, meth_en_o=0, value_o=0, missed_o=0; after release, no EN until a new trigger.
- SCHED_RDY_TIMEOUT_EN, TIMEOUT_CYC=8, step with RDY=0 -> return to IDLE after 8 cycles, timeout_o=1, no EN; a later step with RDY=1 completes normally and timeout_o stays 1.

Source files
------------

// File: rtl/counter_call_sched.sv
// Call scheduler for an EN/RDY/RV action-value method: issues one call per prescaler tick
// (run mode) or per step pulse, captures the returned value and counts dropped triggers.
// Optional RDY timeout is enabled by defining SCHED_RDY_TIMEOUT_EN.
module counter_call_sched #(
  parameter int PRESCALE_W  = 21,
  parameter int RV_W        = 4,
  parameter int MISS_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              run_i,
  input  logic              step_i,
  input  logic [4:0]        div_sel_i,
  input  logic              meth_rdy_i,
  input  logic [RV_W-1:0]   meth_rv_i,
  output logic              meth_en_o,
  output logic [RV_W-1:0]   value_o,
  output logic              value_vld_o,
  output logic              busy_o,
  output logic [MISS_W-1:0] missed_o,
  output logic              timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [4:0] clamp_idx(input logic [4:0] sel);
    return (int'(sel) > PRESCALE_W - 1) ? 5'(PRESCALE_W - 1) : sel;
  endfunction

  state_t                state_p0;
  state_t                state_n;
  logic [PRESCALE_W-1:0] presc_p0;
  logic                  prev_bit_p0;
  logic [PRESCALE_W-1:0] sel_mask;
  logic                  sel_bit;
  logic                  tick;
  logic                  trigger;
  logic                  timeout_hit;

  // Stage 0: prescaler and rising-edge detect on the selected bit
  always_comb begin
    sel_mask = {{(PRESCALE_W-1){1'b0}}, 1'b1} << clamp_idx(div_sel_i);
    sel_bit  = |(presc_p0 & sel_mask);
    tick     = sel_bit & ~prev_bit_p0;
    trigger  = run_i ? tick : step_i;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_p0    <= '0;
      prev_bit_p0 <= 1'b0;
    end else begin
      presc_p0    <= presc_p0 + 1'b1;
      prev_bit_p0 <= sel_bit;
    end
  end

`ifdef SCHED_RDY_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_p0;
  logic              timeout_p0;

  // The expiring cycle is the TIMEOUT_CYC-th consecutive PEND cycle without RDY
  assign timeout_hit = (state_p0 == PEND) && !meth_rdy_i &&
                       (wait_p0 == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_p0    <= '0;
      timeout_p0 <= 1'b0;
    end else begin
      if (state_p0 == IDLE) begin
        wait_p0 <= '0;
      end else if (!meth_rdy_i) begin
        wait_p0 <= wait_p0 + 1'b1;
      end
      if (timeout_hit) begin
        timeout_p0 <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_p0;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Stage 1: call FSM; EN is combinational from RDY so it can never precede readiness
  always_comb begin
    state_n   = state_p0;
    meth_en_o = 1'b0;
    busy_o    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (trigger) begin
          state_n = PEND;
        end
      end
      PEND: begin
        busy_o = 1'b1;
        if (meth_rdy_i) begin
          meth_en_o = 1'b1;
          state_n   = IDLE;
        end else if (timeout_hit) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_n;
    end
  end

  // Stage 2: capture of the returned value and dropped-trigger accounting
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      value_o     <= '0;
      value_vld_o <= 1'b0;
      missed_o    <= '0;
    end else begin
      value_vld_o <= meth_en_o;
      if (meth_en_o) begin
        value_o <= meth_rv_i;
      end
      if ((state_p0 == PEND) && trigger) begin
        missed_o <= sat_inc(missed_o);
      end
    end
  end

endmodule
